// File: rtl/store_unit.sv
// Store unit: word-aligned memory write beats with byte strobes.
// Define STORE_SPLIT_EN to split boundary-crossing stores into two beats.
module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              done,
  output logic              fault,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_t;

  state_t            r_state;
  logic              r_wvalid;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_done;
  logic              r_fault;
  logic              r_split;
  logic [31:0]       r_b1_wdata;
  logic [3:0]        r_b1_wstrb;

  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [6:0]        w_wide;
  logic              w_split;
  logic              w_illegal;
  logic              w_accept;
  logic [31:0]       w_bmask;
  logic [63:0]       w_sh;

  assign w_off = req_addr[1:0];

  always_comb begin
    w_mask = 4'b0000;
    case (req_size)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  assign w_wide  = {3'b000, w_mask} << w_off;
  assign w_split = |w_wide[6:4];

  // Zero the unused bytes before lane shifting so idle lanes stay 0
  assign w_bmask = {{8{w_mask[3]}}, {8{w_mask[2]}},
                    {8{w_mask[1]}}, {8{w_mask[0]}}};
  assign w_sh    = {32'b0, req_data & w_bmask} << {w_off, 3'b000};

`ifdef STORE_SPLIT_EN
  assign w_illegal = (req_size == 2'b11);
`else
  assign w_illegal = (req_size == 2'b11) || w_split;
`endif

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wvalid   <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_split    <= 1'b0;
      r_b1_wdata <= '0;
      r_b1_wstrb <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_fault <= 1'b1;
            end else begin
              r_state    <= BEAT0;
              r_wvalid   <= 1'b1;
              r_waddr    <= {req_addr[ADDR_W-1:2], 2'b00};
              r_wdata    <= w_sh[31:0];
              r_wstrb    <= w_wide[3:0];
              r_split    <= w_split;
              r_b1_wdata <= w_sh[63:32];
              r_b1_wstrb <= {1'b0, w_wide[6:4]};
            end
          end
        end
        BEAT0: begin
          if (mem_wready) begin
`ifdef STORE_SPLIT_EN
            if (r_split) begin
              r_state <= BEAT1;
              r_waddr <= r_waddr + ADDR_W'(4);
              r_wdata <= r_b1_wdata;
              r_wstrb <= r_b1_wstrb;
            end else begin
              r_state  <= IDLE;
              r_wvalid <= 1'b0;
              r_waddr  <= '0;
              r_wdata  <= '0;
              r_wstrb  <= '0;
              r_done   <= 1'b1;
            end
`else
            r_state  <= IDLE;
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_done   <= 1'b1;
`endif
          end
        end
        BEAT1: begin
          if (mem_wready) begin
            r_state  <= IDLE;
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_wvalid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wvalid = r_wvalid;
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;
  assign mem_wstrb  = r_wstrb;
  assign done       = r_done;
  assign fault      = r_fault;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: directed and random stores against a
// byte-level reference model.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        fault;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          e_n;
  logic        e_fault;
  logic [31:0] e_addr [2];
  logic [31:0] e_data [2];
  logic [3:0]  e_strb [2];

  always #5 clk = ~clk;

  store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .done(done), .fault(fault), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk the stored bytes one at a time and bin them by word address.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    int nb;
    logic [31:0] ba, w0;
    logic [1:0]  ln;
    int k;
    e_fault = 1'b0;
    e_n = 1;
    for (int j = 0; j < 2; j++) begin
      e_addr[j] = '0; e_data[j] = '0; e_strb[j] = '0;
    end
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    if (s == 2'd3) begin
      e_fault = 1'b1;
      e_n = 0;
      return;
    end
    w0 = a & 32'hFFFF_FFFC;
    for (int i = 0; i < nb; i++) begin
      ba = a + 32'(i);
      ln = ba[1:0];
      k = ((ba & 32'hFFFF_FFFC) == w0) ? 0 : 1;
      if (k == 1) e_n = 2;
      e_addr[k] = ba & 32'hFFFF_FFFC;
      e_data[k][8*ln +: 8] = d[8*i +: 8];
      e_strb[k][ln] = 1'b1;
    end
`ifndef STORE_SPLIT_EN
    if (e_n == 2) begin
      e_fault = 1'b1;
      e_n = 0;
    end
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of
  // the done (or fault) cycle so the next store can be accepted there.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input int stall);
    int cyc;
    logic wr;
    model(a, d, s);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom;
    if (e_fault) begin
      chk("fault_pulse", {31'b0, fault}, 32'd1);
      chk("fault_nobeat", {31'b0, mem_wvalid}, 32'd0);
      chk("fault_ready", {31'b0, req_ready}, 32'd1);
      chk("fault_busy", {31'b0, busy}, 32'd0);
      return;
    end
    for (int k = 0; k < e_n; k++) begin
      cyc = 0;
      wr = 1'b0;
      while (!wr) begin
        chk("wvalid", {31'b0, mem_wvalid}, 32'd1);
        chk("waddr", mem_waddr, e_addr[k]);
        chk("wdata", mem_wdata, e_data[k]);
        chk("wstrb", {28'b0, mem_wstrb}, {28'b0, e_strb[k]});
        chk("busy", {31'b0, busy}, 32'd1);
        chk("ready_busy", {31'b0, req_ready}, 32'd0);
        chk("no_done", {31'b0, done}, 32'd0);
        chk("no_fault", {31'b0, fault}, 32'd0);
        wr = !(k == 0 && cyc < stall);
        mem_wready = wr;
        @(negedge clk);
        cyc++;
        if (cyc > 20) begin
          chk("beat_timeout", 32'(cyc), 32'd0);
          return;
        end
      end
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_wvalid", {31'b0, mem_wvalid}, 32'd0);
    chk("done_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int st;
    logic [31:0] ra;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    mem_wready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_wvalid", {31'b0, mem_wvalid}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_store(32'h0000_1003, 32'h0000_00AB, 2'd0, 0);
    run_store(32'h0000_2002, 32'h0000_1234, 2'd1, 0);
    run_store(32'h0000_3000, 32'hDEAD_BEEF, 2'd2, 0);
    run_store(32'h0000_4001, 32'hAABB_CCDD, 2'd2, 0);
    run_store(32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, 0);
    run_store(32'h0000_5000, 32'h1122_3344, 2'd2, 3);
    run_store(32'h0000_6001, 32'h0000_0055, 2'd3, 0);
    run_store(32'h0000_7000, 32'h0102_0304, 2'd2, 0);
    run_store(32'h0000_8003, 32'hFFFF_FFFF, 2'd0, 0);

    // Reset in the final beat abandons the store without done
    req_valid = 1'b1;
`ifdef STORE_SPLIT_EN
    req_addr = 32'h0000_4001;
`else
    req_addr = 32'h0000_4000;
`endif
    req_data = 32'hAABB_CCDD;
    req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rs_beat0", {31'b0, mem_wvalid}, 32'd1);
`ifdef STORE_SPLIT_EN
    mem_wready = 1'b1;
    @(negedge clk);
    chk("rs_beat1", {31'b0, mem_wvalid}, 32'd1);
    chk("rs_beat1_addr", mem_waddr, 32'h0000_4004);
`endif
    mem_wready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rs_wvalid", {31'b0, mem_wvalid}, 32'd0);
    chk("rs_done", {31'b0, done}, 32'd0);
    chk("rs_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    mem_wready = 1'b1;
    @(negedge clk);
    chk("rs_done2", {31'b0, done}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_store(ra, $urandom, 2'($urandom_range(0, 3)), st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Store path of the data-memory interface: the write-side counterpart to the writeback select stage that routes ALU, load-word and load-byte data into the register file. Accepts one store request per handshake from the core (byte, halfword or word at any byte address) and issues word-aligned memory write beats with byte strobes. Misaligned stores that cross a word boundary are optionally split into two beats. Sits between the execute stage and the data-memory write port; `busy` stalls the core.

## Interface
- `ADDR_W`, 32: byte-address width; data width is fixed at 32.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core store request valid
- `req_ready`  out  1  unit can accept a request
- `req_addr`  in  ADDR_W  byte address
- `req_data`  in  32  store data, LSB-justified
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `mem_wvalid`  out  1  write beat valid
- `mem_wready`  in  1  memory accepts beat
- `mem_waddr`  out  ADDR_W  word-aligned address, bits [1:0] always 0
- `mem_wdata`  out  32  lane-positioned write data
- `mem_wstrb`  out  4  byte strobes, bit i enables byte lane i
- `done`  out  1  one-cycle pulse: store fully written
- `fault`  out  1  one-cycle pulse: request rejected, no beat issued
- `busy`  out  1  high while a store is in flight (state not IDLE)

## Operation
- FSM states: IDLE, BEAT0, BEAT1.
- `req_ready` = (state == IDLE) && !rst. Request accepted on `req_valid && req_ready`; addr/data/size captured.
- off = `req_addr[1:0]`; mask = 0001 (byte), 0011 (half), 1111 (word); wide = mask << off (7 bits); split = |wide[6:4].
- BEAT0: `mem_waddr` = {addr[ADDR_W-1:2], 2'b00}; `mem_wdata` = data << 8*off (truncated to 32); `mem_wstrb` = wide[3:0].
- BEAT1: `mem_waddr` = BEAT0 address + 4, modulo 2^ADDR_W (0x...FFFC wraps to 0x0); `mem_wdata` = data >> 8*(4-off); `mem_wstrb` = wide[6:4] zero-extended to 4 bits.
- Transitions: IDLE -> BEAT0 on accept of a legal request; BEAT0 -> BEAT1 on `mem_wready` if split, else -> IDLE; BEAT1 -> IDLE on `mem_wready`.
- `mem_wvalid` high in BEAT0/BEAT1 only; address/data/strobe stable while `mem_wvalid && !mem_wready`. Strobe is never 0 on a valid beat.
- `done` pulses the cycle after the final beat handshake. A new request may be accepted in that same cycle.
- `req_size` = 11: request accepted, no beat, FSM stays IDLE, `fault` pulses next cycle.
- Unused lanes of `mem_wdata` are driven 0.

## Timing
- Reset values: `mem_wvalid`, `mem_waddr`, `mem_wdata`, `mem_wstrb`, `done`, `fault`, `busy` all 0; `req_ready` 0 while `rst` high, 1 the first cycle after.
- Accept at edge T: `mem_wvalid` high in cycle T+1 (registered outputs, no combinational path from req_* to mem_*).
- With `mem_wready` tied high: aligned store `done` at T+2; split store beats at T+1 and T+2, `done` at T+3.
- Back-to-back stores: one every 2 cycles (aligned), every 3 (split).
- `rst` mid-store: next edge returns to IDLE, `mem_wvalid` drops, remaining beat abandoned, no `done`.
- Illegal size: `fault` at T+1, `req_ready` stays high throughout.

## Configuration
- `STORE_SPLIT_EN` defined: boundary-crossing stores (half at off 3, word at off 1-3) are issued as two beats as above.
- Not defined: BEAT1 omitted; any store with split = 1 is treated like size 11 — accepted, no beat, `fault` pulse at T+1. Aligned/contained stores unchanged.

## Test plan
- SB addr 0x1003, data 0x000000AB, wready=1 -> one beat waddr 0x1000, wdata 0xAB000000, wstrb 1000, `done` at T+2.
- SH addr 0x2002, data 0x1234 -> waddr 0x2000, wdata 0x12340000, wstrb 1100; SW addr 0x3000, data 0xDEADBEEF -> wstrb 1111.
- SW addr 0x4001, data 0xAABBCCDD, STORE_SPLIT_EN -> beat0 0x4000/0xBBCCDD00/1110, beat1 0x4004/0x000000AA/0001, `done` at T+3; without macro -> no beat, `fault` at T+1.
- SH addr 0xFFFFFFFF, data 0xBEEF, split on -> beat0 0xFFFFFFFC/0xEF000000/1000, beat1 0x00000000/0x000000BE/0001.
- Hold `mem_wready` low 3 cycles during beat0 -> addr/data/strobe unchanged, `req_ready` 0, `busy` 1; assert `rst` in BEAT1 -> next cycle `mem_wvalid` 0, no `done`.
- req_size 11 -> no `mem_wvalid`, `fault` one cycle at T+1, next request accepted at T+1.
